vga_timing_gen: RTL and testbench

Parametrised raster timing generator and the successor to the fixed 640x480 sync block.
- Produces hsync, vsync, video_on, pixel coordinates and line/frame strobes for any mode selected by parameters.
- Supports programmable sync polarity, an integer pixel-clock divider and a run/freeze enable.
- Sits between the system clock and the pixel/graphics pipeline; all outputs except p_tick are registered and mutually aligned.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v counters and a
// registered, mutually aligned sync/coordinate/strobe output stage.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        HS_ACT       = 1'(HSYNC_POL);
  localparam logic        VS_ACT       = 1'(VSYNC_POL);

  // Reject degenerate modes and counters too narrow for the totals
  if (H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      CLK_DIV == 0 || CNT_W == 0 ||
      ((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_param
    $error("vga_timing_gen: unsupported parameter set");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             h_wrap_q;
  logic             v_wrap_q;
  logic             hs_win;
  logic             vs_win;
  logic             vis;

  assign tick   = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign p_tick = tick;
  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign hs_win = (h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END));
  assign vs_win = (v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END));
  assign vis    = (h_cnt < CNT_W'(H_DISPLAY)) && (v_cnt < CNT_W'(V_DISPLAY));

  // Pixel-clock divider; holds its phase while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (tick) div_cnt <= '0;
      else      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Wrap flags delay the strobes so they line up with the registered coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_wrap_q <= 1'b0;
      v_wrap_q <= 1'b0;
    end else begin
      h_wrap_q <= tick && h_last;
      v_wrap_q <= tick && h_last && v_last;
    end
  end

  // Output stage: one clk behind the counters, all fields from the same state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_win ? HS_ACT : ~HS_ACT;
      vsync       <= vs_win ? VS_ACT : ~VS_ACT;
      video_on    <= vis;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      line_start  <= h_wrap_q;
      frame_start <= v_wrap_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-mode instances (divided/active-low and
// undivided/active-high) checked every clk against a behavioural raster model.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = 14, VT = 7;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          von;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          ls;
    logic          fs;
  } obs_t;

  typedef struct {
    int   div;
    int   h;
    int   v;
    logic lw;
    logic fw;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  logic pt0, hs0, vs0, von0, ls0, fs0;
  logic pt1, hs1, vs1, von1, ls1, fs1;
  logic [CW-1:0] px0, py0, px1, py1;

  int pol[2]       = '{0, 1};
  int div_n[2]     = '{2, 1};
  int period[2]    = '{196, 98};
  int first_fs[2]  = '{197, 99};

  mdl_t m[2];
  obs_t q0[$];
  obs_t q1[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_rel = 0;
  int   last_fs[2];
  bit   seen_fs[2];
  bit   timing_ok = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(2), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(pt0),
    .hsync(hs0), .vsync(vs0), .video_on(von0), .pixel_x(px0), .pixel_y(py0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .CNT_W(CW)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(pt1),
    .hsync(hs1), .vsync(vs1), .video_on(von1), .pixel_x(px1), .pixel_y(py1),
    .line_start(ls1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic obs_t act(input int i);
    if (i == 0) return {hs0, vs0, von0, px0, py0, ls0, fs0};
    return {hs1, vs1, von1, px1, py1, ls1, fs1};
  endfunction

  function automatic obs_t reset_obs(input int i);
    obs_t r;
    r    = '0;
    r.hs = (pol[i] == 0);
    r.vs = (pol[i] == 0);
    return r;
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    logic hact, vact;
    hact  = (m[i].h >= HD + HF) && (m[i].h < HD + HF + HS);
    vact  = (m[i].v >= VD + VF) && (m[i].v < VD + VF + VS);
    o.hs  = (pol[i] == 1) ? hact : !hact;
    o.vs  = (pol[i] == 1) ? vact : !vact;
    o.von = (m[i].h < HD) && (m[i].v < VD);
    o.px  = CW'(m[i].h);
    o.py  = CW'(m[i].v);
    o.ls  = m[i].lw;
    o.fs  = m[i].fw;
    return o;
  endfunction

  // Queue the outputs expected after the coming edge, then step the model
  task automatic predict();
    for (int i = 0; i < 2; i++) begin
      logic tk;
      if (i == 0) q0.push_back(model_obs(0));
      else        q1.push_back(model_obs(1));
      tk = enable && (m[i].div == div_n[i] - 1);
      m[i].lw = tk && (m[i].h == HT - 1);
      m[i].fw = m[i].lw && (m[i].v == VT - 1);
      if (enable) m[i].div = tk ? 0 : m[i].div + 1;
      if (tk) begin
        if (m[i].h == HT - 1) begin
          m[i].h = 0;
          m[i].v = (m[i].v == VT - 1) ? 0 : m[i].v + 1;
        end else begin
          m[i].h = m[i].h + 1;
        end
      end
    end
  endtask

  task automatic compare();
    n_rel++;
    for (int i = 0; i < 2; i++) begin
      obs_t a, e;
      a = act(i);
      if (i == 0 && q0.size() > 0) begin
        e = q0.pop_front();
        chk("outputs0", 32'(a), 32'(e));
      end else if (i == 1 && q1.size() > 0) begin
        e = q1.pop_front();
        chk("outputs1", 32'(a), 32'(e));
      end
      chk($sformatf("p_tick%0d", i), 32'((i == 0) ? pt0 : pt1),
          32'(enable && (m[i].div == div_n[i] - 1)));
      if (!timing_ok) last_fs[i] = -1;
      else if (a.fs) begin
        if (!seen_fs[i]) begin
          chk($sformatf("first_frame_start%0d", i), 32'(n_rel), 32'(first_fs[i]));
          seen_fs[i] = 1'b1;
        end else if (last_fs[i] >= 0) begin
          chk($sformatf("frame_period%0d", i), 32'(n_rel - last_fs[i]), 32'(period[i]));
        end
        last_fs[i] = n_rel;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      predict();
      @(negedge clk);
      compare();
    end
  endtask

  // Async reset placed between edges, then released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("reset_async%0d", i), 32'(act(i)), 32'(reset_obs(i)));
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("reset_hold%0d", i), 32'(act(i)), 32'(reset_obs(i)));
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m[i] = '{div: 0, h: 0, v: 0, lw: 1'b0, fw: 1'b0};
      seen_fs[i] = 1'b0;
      last_fs[i] = -1;
    end
    n_rel = 0;
    reset = 1'b0;
  endtask

  task automatic wait_pos(input string tag, input int x, input int y);
    int k;
    k = 0;
    while (!(px0 == CW'(x) && py0 == CW'(y)) && k < 1000) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(k < 1000), 32'd1);
  endtask

  initial begin
    int k;
    do_reset();
    cyc(1);
    chk("first_edge_video_on", 32'(von0), 32'd1);

    // Free-running: more than two frames of each instance
    cyc(450);

    // Freeze mid-line for 37 clk, then resume without skipping a pixel
    wait_pos("wait_freeze_point", 5, 1);
    timing_ok = 1'b0;
    enable = 1'b0;
    cyc(37);
    chk("frozen_px", 32'(px0), 32'd5);
    enable = 1'b1;
    k = 0;
    while (px0 == CW'(5) && k < 10) begin
      cyc(1);
      k++;
    end
    chk("resume_px", 32'(px0), 32'd6);
    cyc(40);

    // Irregular enable pattern
    repeat (200) begin
      enable = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    enable = 1'b1;
    cyc(20);
    timing_ok = 1'b1;

    // Reset asserted inside vsync, mid-line
    wait_pos("wait_vsync_point", 3, 5);
    chk("vsync_active_before_reset", 32'(vs0), 32'd0);
    do_reset();
    cyc(420);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
